// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch (I-port) and
//               the load/store unit (D-port). Only one transaction is in
//               flight at a time. D-port has fixed priority, and a starvation
//               counter makes sure fetch still gets the port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // Instruction fetch port (read-only)
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    // Load/store port
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic                  d_byte,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    // Memory side
    output logic                  m_req,
    output logic                  m_we,
    output logic                  m_byte,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    input  logic                  m_ready,
    input  logic                  m_rvalid,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    // Four bits cover the full legal starvation range of 1..15.
    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_LIMIT);

    state_t     r_state;
    logic       r_owner;      // 0 = I-port owns the transaction, 1 = D-port
    logic [3:0] r_starveCnt;

    logic w_idle;
    logic w_starved;
    logic w_grantI;
    logic w_grantD;
    logic w_done;

    // Arbitration is only open in IDLE; reset also keeps the grants low.
    assign w_idle    = (r_state == ST_IDLE) && !rst;
    assign w_starved = (r_starveCnt == c_STARVE_MAX);
    assign w_grantI  = w_idle && i_req && (!d_req || w_starved);
    assign w_grantD  = w_idle && d_req && !w_grantI;

    // Completion is only honoured in WAIT; stray responses elsewhere are dropped.
    assign w_done    = (r_state == ST_WAIT) && m_rvalid;

    assign i_gnt     = w_grantI;
    assign d_gnt     = w_grantD;
    assign i_rvalid  = w_done && !r_owner;
    assign d_rvalid  = w_done && r_owner;
    // Read data is forwarded only for loads; stores and idle cycles return zero.
    assign i_rdata   = (i_rvalid && !m_we) ? m_rdata : '0;
    assign d_rdata   = (d_rvalid && !m_we) ? m_rdata : '0;
    assign busy      = (r_state != ST_IDLE);

    // Transaction sequencer: latch the winner, present it to memory, await completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= 1'b0;
            r_starveCnt <= 4'd0;
            m_req       <= 1'b0;
            m_we        <= 1'b0;
            m_byte      <= 1'b0;
            m_addr      <= '0;
            m_wdata     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grantI) begin
                        r_owner     <= 1'b0;
                        r_starveCnt <= 4'd0;
                        m_req       <= 1'b1;
                        m_we        <= 1'b0;
                        m_byte      <= 1'b0;
                        m_addr      <= i_addr;
                        m_wdata     <= '0;
                        r_state     <= ST_ISSUE;
                    end else if (w_grantD) begin
                        r_owner <= 1'b1;
                        // Only a D win over a waiting fetch counts toward starvation.
                        if (i_req && (r_starveCnt != c_STARVE_MAX)) begin
                            r_starveCnt <= r_starveCnt + 4'd1;
                        end
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_byte  <= d_byte;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (m_ready) begin
                        m_req   <= 1'b0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (m_rvalid) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single memory port between instruction fetch (I-port, read-only) and the load/store unit (D-port: LDW/LDB/STW/STB, driven by the control word's memEn/memRW). Exactly one transaction is outstanding at a time. D-port has fixed priority; a starvation counter guarantees fetch progress. Sits between the fetch/LSU stages and the memory model/controller.

Parameters:
ADDR_WIDTH, 16, byte address width on all ports
DATA_WIDTH, 32, read/write data width
STARVE_LIMIT, 4, consecutive D grants while I-port waits before I is forced to win (legal range 1..15)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
i_req  input  1  fetch request, held until i_gnt
i_addr  input  ADDR_WIDTH  fetch address
i_gnt  output  1  fetch request accepted this cycle (combinational)
i_rvalid  output  1  fetch data valid, single-cycle pulse
i_rdata  output  DATA_WIDTH  fetch data
d_req  input  1  load/store request, held until d_gnt
d_we  input  1  0 = load, 1 = store
d_byte  input  1  1 = byte access (LDB/STB), 0 = word
d_addr  input  ADDR_WIDTH  data address
d_wdata  input  DATA_WIDTH  store data
d_gnt  output  1  data request accepted this cycle (combinational)
d_rvalid  output  1  load data valid / store complete, single-cycle pulse
d_rdata  output  DATA_WIDTH  load data
m_req  output  1  memory request (registered)
m_we  output  1  memory write enable (registered)
m_byte  output  1  byte access (registered)
m_addr  output  ADDR_WIDTH  memory address (registered)
m_wdata  output  DATA_WIDTH  memory write data (registered)
m_ready  input  1  memory accepts m_req this cycle
m_rvalid  input  1  memory completion (reads and writes)
m_rdata  input  DATA_WIDTH  memory read data
busy  output  1  1 whenever state != IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT. Owner register: 0 = I, 1 = D.
- Reset (async, immediate): state IDLE, owner 0, starve_cnt 0, all m_* registers 0, all gnt/rvalid 0, rdata outputs 0, busy 0.
- IDLE: winner chosen combinationally. Only one requester -> it wins. Both -> D wins unless starve_cnt == STARVE_LIMIT, in which case I wins. Winner's gnt = 1 same cycle; its fields latched into m_* regs (I-port: m_we = 0, m_byte = 0, m_wdata = 0); owner set; next state ISSUE. No request -> stay IDLE, gnt = 0.
- starve_cnt: +1 on each D grant while i_req = 1; cleared on any I grant; saturates at STARVE_LIMIT.
- ISSUE: m_req = 1 with stable fields. m_ready = 1 -> next state WAIT, m_req deasserted next cycle. m_ready = 0 -> hold all m_* unchanged.
- WAIT: m_req = 0. On m_rvalid: owner's x_rvalid = 1 that cycle (combinational forward); x_rdata = m_rdata for loads, 0 for stores; other port's rvalid = 0; next state IDLE.
- No gnt is ever asserted outside IDLE. Minimum turnaround: gnt cycle 0, m_req cycle 1, m_rvalid earliest cycle 2, next gnt cycle 3.
- m_rvalid in IDLE or ISSUE is ignored: no rvalid pulse, no state change. This covers a stale response after a mid-transaction reset.
- m_ready outside ISSUE is ignored.
- rdata outputs return to 0 in every cycle without a corresponding rvalid.

Test Plan:
- Lone fetch: i_req = 1, i_addr = 0x0010; m_ready = 1 in cycle 1; m_rvalid = 1, m_rdata = 0xDEADBEEF in cycle 2 -> i_gnt in cycle 0; m_req = 1, m_addr = 0x0010, m_we = 0 in cycle 1; i_rvalid = 1, i_rdata = 0xDEADBEEF in cycle 2; busy = 0 in cycle 3.
- Contention: i_req and d_req rise together (d_addr = 0x0200, load) -> d_gnt = 1, i_gnt = 0; after D completes, I is granted at the next IDLE.
- Starvation: STARVE_LIMIT = 4, i_req and d_req held high, memory responds every transaction -> grants D, D, D, D, I, then D again; starve_cnt returns to 0.
- Byte store with stall: d_we = 1, d_byte = 1, d_addr = 0x0103, d_wdata = 0x000000AB; m_ready low for 3 cycles -> m_req and fields stable for 4 cycles; on m_rvalid, d_rvalid = 1, d_rdata = 0, i_rvalid = 0.
- Reset in WAIT: assert rst mid-transaction -> all outputs 0 immediately; a stray m_rvalid after release produces no rvalid pulse, and the next i_req is granted normally.
- Spurious m_rvalid in IDLE: no rvalid pulse; state remains IDLE.
